// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch and the
// memory stage. Data accesses win by default, but once MAX_D_STREAK data
// grants have been issued back-to-back while fetch was waiting, fetch gets
// the next slot. Requesters use a req/done handshake; the memory side is a
// req/ack port whose latency may be zero or more cycles.
//
// Timing: a request sampled in IDLE at edge t raises mem_req after t. The ack
// sampled at edge a (a >= t+1) produces the done pulse after a. The cycle
// after that is RESP, and the arbiter can grant again at edge a+2.
// Requests are ignored in RESP, so a requester may drop or replace its
// request while its done pulse is visible.

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    logic [1:0]          state_q,     state_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          mem_size_q,  mem_size_d;
    logic                if_done_q,   if_done_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic                d_done_q,    d_done_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                owner_q,     owner_d;
    logic                busy_q,      busy_d;

    // Data wins in IDLE unless fetch is waiting and the streak has run out.
    logic                grant_d_s;
    logic [STREAK_W-1:0] streak_inc_s;

    assign grant_d_s    = d_req && (!if_req || (streak_q != STREAK_MAX));
    assign streak_inc_s = (streak_q == STREAK_MAX) ? streak_q : (streak_q + STREAK_ONE);

    // Next-state, grant latching, completion capture and streak bookkeeping.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_done_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        owner_d     = owner_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_size_d  = d_size;
                    owner_d     = 1'b1;
                    busy_d      = 1'b1;
                    // Only consecutive data grants that kept fetch waiting count.
                    streak_d    = if_req ? streak_inc_s : {STREAK_W{1'b0}};
                end else if (if_req) begin
                    state_d     = ST_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = {DATA_W{1'b0}};
                    mem_size_d  = 2'd2;
                    owner_d     = 1'b0;
                    busy_d      = 1'b1;
                    streak_d    = {STREAK_W{1'b0}};
                end else begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                end
            end
            ST_BUSY_I: begin
                if (mem_ack) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end else begin
                    mem_req_d  = 1'b1;
                end
            end
            ST_BUSY_D: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    // A store completes without disturbing the last load result.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            streak_q    <= {STREAK_W{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_size_q  <= 2'd0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            d_done_q    <= 1'b0;
            d_rdata_q   <= {DATA_W{1'b0}};
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

    mem_port_arbiter_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clock     (clock),
        .reset     (reset),
        .if_done   (if_done_q),
        .d_done    (d_done_q),
        .mem_req   (mem_req_q),
        .mem_ack   (mem_ack),
        .mem_we    (mem_we_q),
        .mem_addr  (mem_addr_q),
        .mem_wdata (mem_wdata_q),
        .mem_size  (mem_size_q),
        .owner     (owner_q),
        .busy      (busy_q)
    );

endmodule

// Protocol properties of the arbiter outputs.
module mem_port_arbiter_checker #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clock,
    input logic              reset,
    input logic              if_done,
    input logic              d_done,
    input logic              mem_req,
    input logic              mem_ack,
    input logic              mem_we,
    input logic [ADDR_W-1:0] mem_addr,
    input logic [DATA_W-1:0] mem_wdata,
    input logic [1:0]        mem_size,
    input logic              owner,
    input logic              busy
);

    a_done_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(if_done && d_done))
        else $error("both done pulses asserted together");

    a_done_single_cycle: assert property (@(posedge clock) disable iff (reset)
        (if_done || d_done) |=> !(if_done || d_done))
        else $error("done pulse longer than one cycle");

    a_req_stable: assert property (@(posedge clock) disable iff (reset)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr) && $stable(mem_we)
                                   && $stable(mem_wdata) && $stable(mem_size) && $stable(owner)))
        else $error("memory request changed before ack");

    a_req_drop: assert property (@(posedge clock) disable iff (reset)
        (mem_req && mem_ack) |=> !mem_req)
        else $error("memory request held after ack");

    a_req_busy: assert property (@(posedge clock) disable iff (reset)
        mem_req |-> busy)
        else $error("memory request while not busy");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter. Requesters push the
// expected access into per-port queues when they raise req; a monitor decides
// from the arbitration rules who should win each free slot and checks grants,
// held memory fields, done pulses and read data against those queues.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAX_D  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [1:0]        d_size = 2'd0;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              owner;
    logic              busy;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_D)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rdata;
    } req_t;

    req_t if_q[$];
    req_t d_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold_ack = 1'b0;
    bit   spurious_en = 1'b1;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h0101_0101;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue_if();
        req_t r;
        r.addr  = 32'h0100_0000 + (32'($urandom_range(0, 1023)) << 2);
        r.we    = 1'b0;
        r.wdata = 32'h0;
        r.size  = 2'd2;
        r.rdata = mem_fn(r.addr);
        if_addr = r.addr;
        if_req  = 1'b1;
        if_q.push_back(r);
    endtask

    task automatic issue_d();
        req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = 32'h0200_0000 + 32'($urandom_range(0, 65535));
        r.wdata = $urandom;
        r.size  = 2'($urandom_range(0, 2));
        r.rdata = mem_fn(r.addr);
        d_we    = r.we;
        d_addr  = r.addr;
        d_wdata = r.wdata;
        d_size  = r.size;
        d_req   = 1'b1;
        d_q.push_back(r);
    endtask

    // Requesters: drop req on done, then re-request with the given percentages.
    task automatic run_random(input int n, input int pct_if, input int pct_d);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #2;
            if (if_done) if_req = 1'b0;
            if (d_done)  d_req  = 1'b0;
            if (!if_req && ($urandom_range(0, 99) < pct_if)) issue_if();
            if (!d_req  && ($urandom_range(0, 99) < pct_d))  issue_d();
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #2;
            if (if_done) if_req = 1'b0;
            if (d_done)  d_req  = 1'b0;
            if (!if_req && !d_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_complete", 32'(ok), 32'd1);
    endtask

    // Memory model: latency 0..3 cycles after mem_req, occasional stray acks.
    initial begin : responder
        bit in_flight;
        int wait_n;
        in_flight = 1'b0;
        wait_n = 0;
        forever begin
            @(posedge clock); #3;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (reset) begin
                in_flight = 1'b0;
            end else begin
                if (mem_req && !in_flight) begin
                    in_flight = 1'b1;
                    wait_n = $urandom_range(0, 3);
                end
                if (in_flight) begin
                    if (!hold_ack) begin
                        if (wait_n == 0) begin
                            mem_ack   = 1'b1;
                            mem_rdata = mem_fn(mem_addr);
                            in_flight = 1'b0;
                        end else begin
                            wait_n--;
                        end
                    end
                end else if (spurious_en && ($urandom_range(0, 7) == 0)) begin
                    mem_ack = 1'b1;
                end
            end
        end
    end

    // Reference model and scoreboard, evaluated just after every clock edge
    // using the request/ack values that were sampled at that edge.
    initial begin : monitor
        int          next_free;
        int          streak;
        bit          active;
        bit          own;
        bit          win;
        req_t        cur;
        logic [31:0] last_if;
        logic [31:0] last_d;
        next_free = 0; streak = 0; active = 1'b0; own = 1'b0; win = 1'b0;
        last_if = 32'h0; last_d = 32'h0;
        cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, size: 2'd0, rdata: 32'h0};
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (reset) begin
                chk("reset_ctrl", {26'd0, if_done, d_done, mem_req, mem_we, owner, busy}, 32'd0);
                chk("reset_mem_addr", mem_addr, 32'd0);
                chk("reset_mem_wdata", mem_wdata, 32'd0);
                chk("reset_mem_size", {30'd0, mem_size}, 32'd0);
                chk("reset_if_rdata", if_rdata, 32'd0);
                chk("reset_d_rdata", d_rdata, 32'd0);
                next_free = cyc + 1; streak = 0; active = 1'b0;
                last_if = 32'h0; last_d = 32'h0;
                if_q.delete();
                d_q.delete();
            end else begin
                if (!active && (cyc >= next_free) && (if_req || d_req)) begin
                    if (if_req && d_req) win = (streak == MAX_D) ? 1'b0 : 1'b1;
                    else                 win = d_req;
                    chk("grant_queue_nonempty", 32'(win ? (d_q.size() != 0) : (if_q.size() != 0)), 32'd1);
                    if (win && d_q.size() != 0)       cur = d_q[0];
                    else if (!win && if_q.size() != 0) cur = if_q[0];
                    chk("grant_mem_req", 32'(mem_req), 32'd1);
                    chk("grant_owner", 32'(owner), 32'(win));
                    chk("grant_busy", 32'(busy), 32'd1);
                    chk("grant_mem_we", 32'(mem_we), 32'(cur.we));
                    chk("grant_mem_addr", mem_addr, cur.addr);
                    chk("grant_mem_wdata", mem_wdata, cur.wdata);
                    chk("grant_mem_size", 32'(mem_size), 32'(cur.size));
                    chk("grant_no_done", {30'd0, if_done, d_done}, 32'd0);
                    if (win) streak = if_req ? ((streak < MAX_D) ? streak + 1 : MAX_D) : 0;
                    else     streak = 0;
                    active = 1'b1;
                    own = win;
                end else if (active) begin
                    if (mem_ack) begin
                        chk("done_mem_req_low", 32'(mem_req), 32'd0);
                        chk("done_if_pulse", 32'(if_done), 32'(!own));
                        chk("done_d_pulse", 32'(d_done), 32'(own));
                        chk("done_busy", 32'(busy), 32'd1);
                        if (own) begin
                            if (d_q.size() != 0) d_q.delete(0);
                            if (!cur.we) last_d = cur.rdata;
                        end else begin
                            if (if_q.size() != 0) if_q.delete(0);
                            last_if = cur.rdata;
                        end
                        active = 1'b0;
                        next_free = cyc + 2;
                    end else begin
                        chk("hold_mem_req", 32'(mem_req), 32'd1);
                        chk("hold_owner", 32'(owner), 32'(own));
                        chk("hold_mem_addr", mem_addr, cur.addr);
                        chk("hold_mem_we_wdata", {mem_we, mem_wdata[30:0]}, {cur.we, cur.wdata[30:0]});
                        chk("hold_no_done", {30'd0, if_done, d_done}, 32'd0);
                    end
                end else begin
                    chk("idle_ctrl", {28'd0, if_done, d_done, mem_req, busy}, 32'd0);
                end
                chk("if_rdata_value", if_rdata, last_if);
                chk("d_rdata_value", d_rdata, last_d);
            end
        end
    end

    initial begin : stimulus
        bit seen;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;

        run_random(1500, 20, 25);
        run_random(1500, 100, 100);
        run_random(800, 60, 60);
        drain();

        // Reset in the middle of a data access whose ack never comes.
        hold_ack = 1'b1;
        spurious_en = 1'b0;
        issue_d();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #2;
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_grant_seen", 32'(seen), 32'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        d_req = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        hold_ack = 1'b0;
        spurious_en = 1'b1;
        repeat (2) @(posedge clock);
        #2;

        // A fresh fetch is served normally after the abort.
        issue_if();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #2;
            if (if_done) begin
                seen = 1'b1;
                if_req = 1'b0;
                break;
            end
        end
        chk("post_reset_fetch_done", 32'(seen), 32'd1);
        if_req = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        chk("if_queue_empty", 32'(if_q.size()), 32'd0);
        chk("d_queue_empty", 32'(d_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
